// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, default device address and
// ACK/NACK bit levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  // Same value the on-board master uses, so loopback needs no configuration.
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h30;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA pad inputs and derives SCL edges plus START/STOP
// bus conditions from the synchronised samples.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl;

  // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address, 8-bit register pointer, auto-increment
// burst writes and repeated-start reads onto a simple register-file port.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       busy
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  i2c_state_e state;
  i2c_state_e state_next;
  logic [7:0] shift_q;
  logic [7:0] byte_in;
  logic [2:0] bit_cnt;
  logic       ack_on;
  logic       rw;
  logic       wr_pend;
  logic       rd_req;
  logic       rd_load;
  logic       last_bit_in;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign byte_in     = {shift_q[6:0], sda_s};
  assign last_bit_in = scl_rise && (bit_cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before any branch, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ADDR:      if (last_bit_in) state_next = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
      ADDR_ACK:  if (scl_fall && ack_on) state_next = rw ? RDATA : REG;
      REG:       if (last_bit_in) state_next = REG_ACK;
      REG_ACK:   if (scl_fall && ack_on) state_next = WDATA;
      WDATA:     if (last_bit_in) state_next = WDATA_ACK;
      WDATA_ACK: if (scl_fall && ack_on) state_next = WDATA;
      RDATA:     if (scl_fall && (bit_cnt == 3'd0)) state_next = RDATA_ACK;
      RDATA_ACK: begin
        if (scl_rise && !ack_on && (sda_s == I2C_NACK)) state_next = IGNORE;
        else if (scl_fall && ack_on)                   state_next = RDATA;
      end
      IDLE, IGNORE: state_next = state;
      default:      state_next = IDLE;
    endcase
    // Bus conditions override any bit-level progress on the same cycle.
    if (stop)       state_next = IDLE;
    else if (start) state_next = ADDR;
  end

  // NOTE: every datapath register, including the shift register, is reset so a
  // mid-transfer reset returns the port to a known, bus-released state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe   <= 1'b0;
      reg_addr <= 8'h00;
      wr_data  <= 8'h00;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      shift_q  <= 8'h00;
      bit_cnt  <= 3'd7;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      wr_pend  <= 1'b0;
      rd_req   <= 1'b0;
      rd_load  <= 1'b0;
    end else begin
      wr_en   <= wr_pend;
      wr_pend <= 1'b0;
      rd_en   <= rd_req;
      rd_req  <= 1'b0;
      rd_load <= rd_en;
      if (wr_en)   reg_addr <= reg_addr + 8'd1;
      if (rd_load) shift_q  <= rd_data;

      if (stop) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end else if (start) begin
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= 3'd7;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                if (state == ADDR && byte_in[7:1] == DEV_ADDR) begin
                  busy <= 1'b1;
                  rw   <= byte_in[0];
                end
                if (state == REG) reg_addr <= byte_in;
                if (state == WDATA) begin
                  wr_data <= byte_in;
                  wr_pend <= 1'b1;
                end
              end
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= ~I2C_ACK;
                ack_on <= 1'b1;
                if (state == ADDR_ACK && rw) rd_en <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd7;
                // A read starts driving its MSB on the same fall that ends the ACK.
                sda_oe  <= (state == ADDR_ACK && rw) ? ~shift_q[7] : 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                sda_oe  <= ~shift_q[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise && !ack_on && (sda_s == I2C_ACK)) begin
              reg_addr <= reg_addr + 8'd1;
              rd_req   <= 1'b1;
              ack_on   <= 1'b1;
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd7;
              sda_oe  <= ~shift_q[7];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
